// File: rtl/mem_arbiter.sv
// Arbitrates a single-ported, fixed-latency memory between the IF and DM ports of the pipeline.
// Optional macro ARB_STATS_EN adds per-port stall-cycle counters.
module mem_arbiter #(
    parameter int unsigned ADDR_W     = 32,
    parameter int unsigned DATA_W     = 32,
    parameter int unsigned MEM_LAT    = 2,
    parameter int unsigned STARVE_MAX = 4
) (
    input  logic              clk_i,
    input  logic              reset_i,
    input  logic              if_req_i,
    input  logic [ADDR_W-1:0] if_addr_i,
    output logic [DATA_W-1:0] if_rdata_o,
    output logic              if_ack_o,
    output logic              if_stall_o,
    input  logic              dm_req_i,
    input  logic              dm_we_i,
    input  logic [ADDR_W-1:0] dm_addr_i,
    input  logic [DATA_W-1:0] dm_wdata_i,
    output logic [DATA_W-1:0] dm_rdata_o,
    output logic              dm_ack_o,
    output logic              dm_stall_o,
`ifdef ARB_STATS_EN
    output logic [31:0]       if_wait_cnt_o,
    output logic [31:0]       dm_wait_cnt_o,
`endif
    output logic              mem_en_o,
    output logic              mem_we_o,
    output logic [ADDR_W-1:0] mem_addr_o,
    output logic [DATA_W-1:0] mem_wdata_o,
    input  logic [DATA_W-1:0] mem_rdata_i
);

    localparam int unsigned CntW = (MEM_LAT > 1) ? $clog2(MEM_LAT) : 1;
    localparam int unsigned StW  = $clog2(STARVE_MAX + 1);

    localparam logic [0:0] StIdle = 1'b0;
    localparam logic [0:0] StBusy = 1'b1;

    localparam logic [CntW-1:0] CntInit   = CntW'(MEM_LAT - 1);
    localparam logic [StW-1:0]  StarveMax = StW'(STARVE_MAX);

    logic [0:0]        state_q, state_d;
    logic [CntW-1:0]   cnt_q, cnt_d;
    logic [StW-1:0]    starve_q, starve_d;
    logic              sel_dm_q, sel_dm_d;
    logic              we_q, we_d;
    logic [ADDR_W-1:0] addr_q, addr_d;
    logic [DATA_W-1:0] wdata_q, wdata_d;
    logic [DATA_W-1:0] if_rdata_q, if_rdata_d;
    logic [DATA_W-1:0] dm_rdata_q, dm_rdata_d;

    logic busy, done, can_grant, gnt_dm, gnt_if;

    assign busy      = (state_q == StBusy);
    assign done      = busy && (cnt_q == '0);
    assign can_grant = !busy || done;

    // DM wins contention unless IF has lost STARVE_MAX times in a row.
    assign gnt_dm = can_grant && dm_req_i && (!if_req_i || (starve_q != StarveMax));
    assign gnt_if = can_grant && if_req_i && !gnt_dm;

    // A dropped request still finishes its access, but gets no ack.
    assign if_ack_o   = done && !sel_dm_q && if_req_i;
    assign dm_ack_o   = done && sel_dm_q && dm_req_i;
    assign if_stall_o = if_req_i && !if_ack_o;
    assign dm_stall_o = dm_req_i && !dm_ack_o;

    assign mem_en_o    = busy;
    assign mem_we_o    = done && we_q;
    assign mem_addr_o  = busy ? addr_q : '0;
    assign mem_wdata_o = busy ? wdata_q : '0;

    assign if_rdata_o = if_ack_o ? mem_rdata_i : if_rdata_q;
    assign dm_rdata_o = dm_ack_o ? mem_rdata_i : dm_rdata_q;

    always_comb begin
        state_d    = state_q;
        cnt_d      = cnt_q;
        starve_d   = starve_q;
        sel_dm_d   = sel_dm_q;
        we_d       = we_q;
        addr_d     = addr_q;
        wdata_d    = wdata_q;
        if_rdata_d = if_rdata_q;
        dm_rdata_d = dm_rdata_q;

        if (busy && !done) begin
            cnt_d = cnt_q - CntW'(1);
        end

        if (gnt_dm || gnt_if) begin
            state_d  = StBusy;
            cnt_d    = CntInit;
            sel_dm_d = gnt_dm;
            we_d     = gnt_dm && dm_we_i;
            addr_d   = gnt_dm ? dm_addr_i : if_addr_i;
            wdata_d  = gnt_dm ? dm_wdata_i : '0;
        end else if (done) begin
            state_d = StIdle;
        end

        if (gnt_if) begin
            starve_d = '0;
        end else if (gnt_dm) begin
            if (!if_req_i) begin
                starve_d = '0;
            end else if (starve_q != StarveMax) begin
                starve_d = starve_q + StW'(1);
            end
        end

        if (if_ack_o) begin
            if_rdata_d = mem_rdata_i;
        end
        if (dm_ack_o) begin
            dm_rdata_d = mem_rdata_i;
        end
    end

    always_ff @(posedge clk_i) begin
        if (reset_i) begin
            state_q    <= StIdle;
            cnt_q      <= '0;
            starve_q   <= '0;
            sel_dm_q   <= 1'b0;
            we_q       <= 1'b0;
            addr_q     <= '0;
            wdata_q    <= '0;
            if_rdata_q <= '0;
            dm_rdata_q <= '0;
        end else begin
            state_q    <= state_d;
            cnt_q      <= cnt_d;
            starve_q   <= starve_d;
            sel_dm_q   <= sel_dm_d;
            we_q       <= we_d;
            addr_q     <= addr_d;
            wdata_q    <= wdata_d;
            if_rdata_q <= if_rdata_d;
            dm_rdata_q <= dm_rdata_d;
        end
    end

`ifdef ARB_STATS_EN
    logic [31:0] if_wait_q, dm_wait_q;

    always_ff @(posedge clk_i) begin
        if (reset_i) begin
            if_wait_q <= '0;
            dm_wait_q <= '0;
        end else begin
            if (if_stall_o && (if_wait_q != '1)) begin
                if_wait_q <= if_wait_q + 32'd1;
            end
            if (dm_stall_o && (dm_wait_q != '1)) begin
                dm_wait_q <= dm_wait_q + 32'd1;
            end
        end
    end

    assign if_wait_cnt_o = if_wait_q;
    assign dm_wait_cnt_o = dm_wait_q;
`endif

endmodule

// File: tb/tb_mem_arbiter.sv
// Directed, scoreboard-based bench for mem_arbiter: MEM_LAT=2 main instance, MEM_LAT=1 second
// instance for single-cycle back-to-back accesses.
module tb_mem_arbiter;

    typedef struct {
        logic        dm;
        logic        we;
        logic [31:0] addr;
        logic [31:0] wdata;
        logic [31:0] rdata;
    } txn_t;

    logic clk, reset;

    logic        if_req, if_ack, if_stall, dm_req, dm_we, dm_ack, dm_stall, mem_en, mem_we;
    logic [31:0] if_addr, if_rdata, dm_addr, dm_wdata, dm_rdata, mem_addr, mem_wdata, mem_rdata;

    logic        f_if_req, f_if_ack, f_if_stall, f_dm_req, f_dm_we, f_dm_ack, f_dm_stall;
    logic        f_mem_en, f_mem_we;
    logic [31:0] f_if_addr, f_if_rdata, f_dm_addr, f_dm_wdata, f_dm_rdata;
    logic [31:0] f_mem_addr, f_mem_wdata, f_mem_rdata;
`ifdef ARB_STATS_EN
    logic [31:0] if_wait_cnt, dm_wait_cnt, f_if_wait_cnt, f_dm_wait_cnt;
`endif

    int   checks = 0;
    int   errors = 0;
    int   n_acks = 0;
    int   if_stall_cyc = 0;
    int   idle_cyc = 0;
    int   we_pulses = 0;
    txn_t exp_q[$];
    txn_t mon_t;

    function automatic logic [31:0] mem_model(input logic [31:0] a);
        return a * 32'd3 + 32'h2002_0005;
    endfunction

    assign mem_rdata   = mem_model(mem_addr);
    assign f_mem_rdata = mem_model(f_mem_addr);

    mem_arbiter #(.ADDR_W(32), .DATA_W(32), .MEM_LAT(2), .STARVE_MAX(4)) u_dut (
        .clk_i(clk), .reset_i(reset),
        .if_req_i(if_req), .if_addr_i(if_addr), .if_rdata_o(if_rdata),
        .if_ack_o(if_ack), .if_stall_o(if_stall),
        .dm_req_i(dm_req), .dm_we_i(dm_we), .dm_addr_i(dm_addr), .dm_wdata_i(dm_wdata),
        .dm_rdata_o(dm_rdata), .dm_ack_o(dm_ack), .dm_stall_o(dm_stall),
`ifdef ARB_STATS_EN
        .if_wait_cnt_o(if_wait_cnt), .dm_wait_cnt_o(dm_wait_cnt),
`endif
        .mem_en_o(mem_en), .mem_we_o(mem_we), .mem_addr_o(mem_addr),
        .mem_wdata_o(mem_wdata), .mem_rdata_i(mem_rdata)
    );

    mem_arbiter #(.ADDR_W(32), .DATA_W(32), .MEM_LAT(1), .STARVE_MAX(1)) u_dut_fast (
        .clk_i(clk), .reset_i(reset),
        .if_req_i(f_if_req), .if_addr_i(f_if_addr), .if_rdata_o(f_if_rdata),
        .if_ack_o(f_if_ack), .if_stall_o(f_if_stall),
        .dm_req_i(f_dm_req), .dm_we_i(f_dm_we), .dm_addr_i(f_dm_addr), .dm_wdata_i(f_dm_wdata),
        .dm_rdata_o(f_dm_rdata), .dm_ack_o(f_dm_ack), .dm_stall_o(f_dm_stall),
`ifdef ARB_STATS_EN
        .if_wait_cnt_o(f_if_wait_cnt), .dm_wait_cnt_o(f_dm_wait_cnt),
`endif
        .mem_en_o(f_mem_en), .mem_we_o(f_mem_we), .mem_addr_o(f_mem_addr),
        .mem_wdata_o(f_mem_wdata), .mem_rdata_i(f_mem_rdata)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic push(input logic dm, input logic we, input logic [31:0] a,
                        input logic [31:0] wd);
        txn_t t;
        t.dm    = dm;
        t.we    = we;
        t.addr  = a;
        t.wdata = wd;
        t.rdata = mem_model(a);
        exp_q.push_back(t);
    endtask

    task automatic wait_acks(input string tag, input int target, input int budget);
        int c = 0;
        while (n_acks < target && c < budget) begin
            tick();
            c++;
        end
        check(tag, n_acks, target);
    endtask

    task automatic wait_idle(input string tag);
        int c = 0;
        while (mem_en && c < 20) begin
            tick();
            c++;
        end
        check(tag, {31'b0, mem_en}, 32'd0);
    endtask

    // Scoreboard: every acked access must match the next expected transaction, in order.
    always @(negedge clk) begin
        if (!reset) begin
            if (if_stall) if_stall_cyc++;
            if (!mem_en) idle_cyc++;
            if (mem_we) we_pulses++;
            if (if_ack || dm_ack) begin
                check("ack_expected", 32'(exp_q.size() > 0), 32'd1);
                check("single_ack", {31'b0, if_ack & dm_ack}, 32'd0);
                if (exp_q.size() > 0) begin
                    mon_t = exp_q.pop_front();
                    check("ack_port", {31'b0, dm_ack}, {31'b0, mon_t.dm});
                    check("mem_addr", mem_addr, mon_t.addr);
                    check("mem_we", {31'b0, mem_we}, {31'b0, mon_t.we});
                    if (mon_t.we) check("mem_wdata", mem_wdata, mon_t.wdata);
                    else if (mon_t.dm) check("dm_rdata", dm_rdata, mon_t.rdata);
                    else check("if_rdata", if_rdata, mon_t.rdata);
                end
                n_acks++;
            end
        end
    end

    initial begin
        int base, base2;
        reset = 1'b1;
        if_req = 0; if_addr = 0; dm_req = 0; dm_we = 0; dm_addr = 0; dm_wdata = 0;
        f_if_req = 0; f_if_addr = 0; f_dm_req = 0; f_dm_we = 0; f_dm_addr = 0; f_dm_wdata = 0;
        tick();
        tick();
        @(negedge clk);
        check("rst_mem_en", {31'b0, mem_en}, 32'd0);
        check("rst_mem_addr", mem_addr, 32'd0);
        check("rst_if_rdata", if_rdata, 32'd0);
        check("rst_dm_rdata", dm_rdata, 32'd0);
        tick();
        reset = 1'b0;

        // 1: lone fetch from 0x0
        push(1'b0, 1'b0, 32'h0, 32'h0);
        base = n_acks; base2 = if_stall_cyc;
        if_req = 1; if_addr = 32'h0;
        wait_acks("t1_ack", base + 1, 20);
        if_req = 0;
        check("t1_stall_cycles", if_stall_cyc - base2, 32'd2);
        @(negedge clk);
        check("t1_if_ack_after_drop", {31'b0, if_ack}, 32'd0);
        check("t1_rdata_held", if_rdata, 32'h2002_0005);
        wait_idle("t1_idle");

        // 2: DM write 241 to 84; strobe is a single-cycle pulse
        push(1'b1, 1'b1, 32'd84, 32'd241);
        base = n_acks;
        dm_req = 1; dm_we = 1; dm_addr = 32'd84; dm_wdata = 32'd241;
        wait_acks("t2_ack", base + 1, 20);
        dm_req = 0; dm_we = 0;
        @(negedge clk);
        check("t2_we_width", {31'b0, mem_we}, 32'd0);
        wait_idle("t2_idle");

        // 3: both held; DM wins four times, then IF is forced through
        for (int r = 0; r < 2; r++) begin
            for (int k = 0; k < 4; k++) push(1'b1, 1'b0, 32'h200, 32'h0);
            push(1'b0, 1'b0, 32'h300, 32'h0);
        end
        base = n_acks;
        if_req = 1; if_addr = 32'h300;
        dm_req = 1; dm_we = 0; dm_addr = 32'h200;
        @(negedge clk);
        #1;
        base2 = idle_cyc;
        wait_acks("t3_acks", base + 10, 60);
        if_req = 0; dm_req = 0;
        check("t3_no_bubble", idle_cyc - base2, 32'd0);
        wait_idle("t3_idle");

        // 5: fetch dropped mid-access while a load waits
        push(1'b1, 1'b0, 32'h100, 32'h0);
        base = n_acks;
        if_req = 1; if_addr = 32'h40;
        tick();
        if_req = 0;
        dm_req = 1; dm_we = 0; dm_addr = 32'h100;
        tick();
        @(negedge clk);
        check("t5_no_if_ack", {31'b0, if_ack}, 32'd0);
        check("t5_if_rdata_kept", if_rdata, mem_model(32'h300));
        tick();
        @(negedge clk);
        check("t5_dm_granted", mem_addr, 32'h100);
        wait_acks("t5_dm_ack", base + 1, 20);
        dm_req = 0;
        wait_idle("t5_idle");

        // 4: reset in first access cycle of a DM write
        base = we_pulses;
        dm_req = 1; dm_we = 1; dm_addr = 32'd80; dm_wdata = 32'h55;
        tick();
        reset = 1; dm_req = 0; dm_we = 0;
        @(negedge clk);
        check("t4_no_strobe", {31'b0, mem_we}, 32'd0);
        tick();
        @(negedge clk);
        check("t4_mem_en", {31'b0, mem_en}, 32'd0);
        check("t4_mem_addr", mem_addr, 32'd0);
        check("t4_mem_wdata", mem_wdata, 32'd0);
        check("t4_if_rdata", if_rdata, 32'd0);
        check("t4_dm_rdata", dm_rdata, 32'd0);
        check("t4_stalls", {30'b0, if_stall, dm_stall}, 32'd0);
        tick();
        reset = 0;
        check("t4_we_pulses", we_pulses - base, 32'd0);

        // 6: MEM_LAT=1, both held, STARVE_MAX=1 -> one ack per cycle, alternating DM/IF
        f_if_req = 1; f_if_addr = 32'h10;
        f_dm_req = 1; f_dm_we = 0; f_dm_addr = 32'h20;
        for (int i = 0; i < 10; i++) begin
            @(negedge clk);
            if (i == 0) check("t6_acks_c0", {30'b0, f_if_ack, f_dm_ack}, 32'd0);
            else if (i % 2 == 1) check("t6_acks_dm", {30'b0, f_if_ack, f_dm_ack}, 32'd1);
            else check("t6_acks_if", {30'b0, f_if_ack, f_dm_ack}, 32'd2);
            if (i == 1) check("t6_dm_rdata", f_dm_rdata, mem_model(32'h20));
            if (i == 2) check("t6_if_rdata", f_if_rdata, mem_model(32'h10));
            if (i < 9) tick();
        end
`ifdef ARB_STATS_EN
        check("t6_dm_wait_cnt", f_dm_wait_cnt, 32'd5);
        check("t6_if_wait_cnt", f_if_wait_cnt, 32'd5);
`endif
        tick();
        f_if_req = 0; f_dm_req = 0;
        tick();
        tick();

        check("queue_drained", exp_q.size(), 32'd0);
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
